// File: rtl/avalon_burst_master.sv
// Avalon-MM burst master: runs one write or read burst per accepted command.
// Optional no-progress watchdog enabled by defining AVM_TIMEOUT_EN.
module avalon_burst_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [10:0] cmd_address,
  input  logic [9:0]  cmd_burstcount,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic [10:0] address,
  output logic        write,
  output logic        read,
  output logic        beginbursttransfer,
  output logic [9:0]  burstcount,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  input  logic        writeresponsevalid,
  input  logic [1:0]  response,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        timeout,
  output logic [2:0]  dbg_state
);
  typedef enum logic [2:0] {IDLE, WR_BURST, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

  state_t      state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic [9:0]  bcnt_q, bcnt_d;
  logic [9:0]  beat_q, beat_d;
  logic        first_q, first_d;
  logic        error_q, error_d;
  logic        timeout_q, timeout_d;
  logic        wr_xfer, rd_acc, rd_beat, wr_resp, beat_last;

  // Handshakes: a command moves on cmd_valid && cmd_ready, a write beat on
  // wdata_valid && wdata_ready (== write && !waitrequest); read beats cannot stall.
  assign wr_xfer   = (state_q == WR_BURST) && wdata_valid && !waitrequest;
  assign rd_acc    = (state_q == RD_REQ) && !waitrequest;
  assign rd_beat   = (state_q == RD_DATA) && readdatavalid;
  assign wr_resp   = (state_q == WR_RESP) && writeresponsevalid;
  assign beat_last = (beat_q + 10'd1) == bcnt_q;

`ifdef AVM_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            progress, active;
  assign progress = wr_xfer || rd_acc || rd_beat || wr_resp;
  assign active   = (state_q == WR_BURST) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_DATA);
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    beat_d    = beat_q;
    first_d   = 1'b0;
    error_d   = error_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_address;
          bcnt_d    = cmd_burstcount;
          beat_d    = '0;
          error_d   = 1'b0;
          timeout_d = 1'b0;
          if (cmd_burstcount == 10'd0) begin
            state_d = DONE;
            error_d = 1'b1;
          end else begin
            first_d = 1'b1;
            state_d = cmd_write ? WR_BURST : RD_REQ;
          end
        end
      end
      WR_BURST: begin
        if (wr_xfer) begin
          beat_d = beat_q + 10'd1;
          if (beat_last) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (wr_resp) begin
          if (response != 2'b00) error_d = 1'b1;
          state_d = DONE;
        end
      end
      RD_REQ: begin
        if (rd_acc) begin
          beat_d  = '0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rd_beat) begin
          beat_d = beat_q + 10'd1;
          if (response != 2'b00) error_d = 1'b1;
          if (beat_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AVM_TIMEOUT_EN
    // Watchdog overrides whatever the burst logic decided this cycle.
    wd_d = '0;
    if (active && !progress) begin
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = DONE;
        error_d   = 1'b1;
        timeout_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      bcnt_q    <= '0;
      beat_q    <= '0;
      first_q   <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef AVM_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bcnt_q    <= bcnt_d;
      beat_q    <= beat_d;
      first_q   <= first_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
`ifdef AVM_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign cmd_ready          = (state_q == IDLE);
  assign address            = addr_q;
  assign burstcount         = bcnt_q;
  assign write              = (state_q == WR_BURST) && wdata_valid;
  assign writedata          = (state_q == WR_BURST) ? wdata : 32'd0;
  assign wdata_ready        = (state_q == WR_BURST) && !waitrequest;
  assign read               = (state_q == RD_REQ);
  assign beginbursttransfer = first_q;
  assign rdata_valid        = rd_beat;
  assign rdata              = rd_beat ? readdata : 32'd0;
  assign busy               = (state_q != IDLE);
  assign done               = (state_q == DONE);
  assign error              = error_q;
  assign dbg_state          = state_q;

`ifdef AVM_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (^TIMEOUT_CYCLES) ^ timeout_q;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_avalon_burst_master.sv
// Self-checking bench for avalon_burst_master: directed bursts, mid-burst reset,
// randomized bursts against a queue-based slave/scoreboard model.
module tb_avalon_burst_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [10:0] cmd_address;
  logic [9:0]  cmd_burstcount;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic [10:0] address;
  logic        write, read, bbt;
  logic [9:0]  burstcount;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid, writeresponsevalid;
  logic [1:0]  response;
  logic        busy, done, error, timeout;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  avalon_burst_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_burstcount(cmd_burstcount),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .address(address), .write(write), .read(read), .beginbursttransfer(bbt),
    .burstcount(burstcount), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid),
    .writeresponsevalid(writeresponsevalid), .response(response),
    .busy(busy), .done(done), .error(error), .timeout(timeout),
    .dbg_state(dbg_state)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          last_rd_cycles;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_address = '0; cmd_burstcount = '0;
    wdata_valid = 0; wdata = '0; waitrequest = 0; readdata = '0;
    readdatavalid = 0; writeresponsevalid = 0; response = 2'b00;
  endtask

  // One command end to end; the bench plays the Avalon slave. bad_idx selects
  // the read beat (or, for writes, any value in range) that returns SLVERR.
  task automatic run_cmd(input bit wr, input logic [10:0] addr, input int bc,
                         input int bad_idx, input bit rnd, input int st_lo,
                         input int st_hi, input logic [31:0] base);
    int          wr_got, rd_sent, bbt_n, cyc;
    bit          rd_acc, resp_sent, done_seen, exp_err, bad_wr;
    logic [31:0] src_q[$];
    wr_got = 0; rd_sent = 0; bbt_n = 0;
    rd_acc = 0; resp_sent = 0; done_seen = 0;
    bad_wr  = wr && bad_idx >= 0 && bad_idx < bc;
    exp_err = (bc == 0) || (bad_idx >= 0 && bad_idx < bc);
    exp_q.delete();
    for (int i = 0; i < bc; i++) begin
      logic [31:0] w;
      w = (base != 0) ? base + 32'(i) : $urandom;
      src_q.push_back(w);
      exp_q.push_back(w);
    end
    last_rd_cycles = 0;
    cmd_valid = 1; cmd_write = wr; cmd_address = addr; cmd_burstcount = 10'(bc);
    #1 check_eq("cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_address = 11'($urandom); cmd_burstcount = 10'($urandom);
    for (cyc = 0; cyc < 6000 && !done_seen; cyc++) begin
      waitrequest = rnd ? ($urandom_range(0, 3) == 0) : (cyc >= st_lo && cyc <= st_hi);
      wdata_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      wdata = (wr_got < bc) ? src_q[wr_got] : $urandom;
      readdatavalid = rd_acc && rd_sent < bc && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      readdata = readdatavalid ? src_q[rd_sent] : $urandom;
      writeresponsevalid = wr && bc > 0 && wr_got == bc && !resp_sent &&
                           (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      response = ((readdatavalid && rd_sent == bad_idx) || (writeresponsevalid && bad_wr))
                 ? 2'b10 : 2'b00;
      #1;
      if (cyc == 0) begin
        check_eq("bbt_first", bbt, bc != 0);
        check_eq("err_clr", error, bc == 0);
      end
      if (bbt) bbt_n++;
      if (busy) begin
        check_eq("addr_hold", address, addr);
        check_eq("bc_hold", burstcount, bc);
      end
      if (write) check_eq("wready", wdata_ready, !waitrequest);
      if (write && !waitrequest) begin
        check_eq("wbeat_in_range", wr_got < bc, 1);
        if (wr_got < bc) check_eq("wbeat", writedata, exp_q.pop_front());
        wr_got++;
      end
      if (read) last_rd_cycles++;
      if (read && !waitrequest) begin
        check_eq("rd_acc_once", rd_acc, 0);
        rd_acc = 1;
      end
      check_eq("rvalid", rdata_valid, readdatavalid);
      if (readdatavalid) begin
        check_eq("rbeat", rdata, exp_q.pop_front());
        rd_sent++;
      end
      if (writeresponsevalid) resp_sent = 1;
      if (done) begin
        done_seen = 1;
        check_eq("done_no_write", write, 0);
        check_eq("done_no_read", read, 0);
      end else begin
        @(posedge clk); #1;
      end
    end
    check_eq("done_seen", done_seen, 1);
    check_eq("error", error, exp_err);
    check_eq("timeout", timeout, 0);
    check_eq("beats", wr ? wr_got : rd_sent, bc);
    check_eq("bbt_count", bbt_n, bc != 0);
    check_eq("rd_req", rd_acc, !wr && bc != 0);
    check_eq("sb_empty", exp_q.size(), 0);
    idle_inputs();
    @(posedge clk); #1;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_done", done, 0);
    check_eq("idle_cmd_ready", cmd_ready, 1);
    check_eq("err_hold", error, exp_err);
  endtask

  task automatic mid_reset();
    cmd_valid = 1; cmd_write = 1; cmd_address = 11'h055; cmd_burstcount = 10'd4;
    @(posedge clk); #1;
    cmd_valid = 0; waitrequest = 0; wdata_valid = 1; wdata = 32'h11;
    @(posedge clk); #1;
    wdata = 32'h22;
    @(posedge clk); #1;
    check_eq("mid_busy_pre", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    check_eq("mid_write", write, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_cmd_ready", cmd_ready, 1);
    check_eq("mid_addr", address, 0);
    check_eq("mid_bc", burstcount, 0);
    check_eq("mid_wready", wdata_ready, 0);
    check_eq("mid_wdata", writedata, 0);
    rst = 0;
    idle_inputs();
    @(posedge clk); #1;
  endtask

`ifdef AVM_TIMEOUT_EN
  task automatic timeout_test();
    int cyc;
    cmd_valid = 1; cmd_write = 1; cmd_address = 11'h020; cmd_burstcount = 10'd4;
    @(posedge clk); #1;
    cmd_valid = 0; waitrequest = 1; wdata_valid = 1; wdata = 32'h5;
    for (cyc = 0; cyc < 100 && !done; cyc++) begin
      @(posedge clk); #1;
    end
    check_eq("to_cycles", cyc, 16);
    check_eq("to_done", done, 1);
    check_eq("to_error", error, 1);
    check_eq("to_flag", timeout, 1);
    check_eq("to_write", write, 0);
    idle_inputs();
    @(posedge clk); #1;
    check_eq("to_hold", timeout, 1);
  endtask
`endif

  initial begin
    idle_inputs();
    rst = 1;
    readdatavalid = 1; wdata_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_write", write, 0);
    check_eq("rst_read", read, 0);
    check_eq("rst_bbt", bbt, 0);
    check_eq("rst_wready", wdata_ready, 0);
    check_eq("rst_rvalid", rdata_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_addr", address, 0);
    check_eq("rst_bc", burstcount, 0);
    check_eq("rst_wdata", writedata, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_state", dbg_state, 0);
    rst = 0;
    #1 check_eq("rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    check_eq("idle_rvalid_ignored", rdata_valid, 0);
    idle_inputs();

    run_cmd(1, 11'h010, 4, -1, 0, 1, 0, 32'h1);
    run_cmd(1, 11'h010, 4, -1, 0, 1, 2, 32'h1);
    run_cmd(0, 11'h100, 3, -1, 0, 0, 1, 32'hA);
    check_eq("rd_held_cycles", last_rd_cycles, 3);
    run_cmd(0, 11'h0c0, 2, 1, 0, 1, 0, 32'h20);
    run_cmd(1, 11'h7ff, 1, 0, 0, 1, 0, 32'h0);
    run_cmd(1, 11'h001, 0, -1, 0, 1, 0, 32'h0);
    run_cmd(0, 11'h002, 0, -1, 0, 1, 0, 32'h0);
    mid_reset();
    run_cmd(1, 11'h033, 4, -1, 1, 0, 0, 32'h0);
    run_cmd(1, 11'h3a5, 1023, -1, 0, 1, 0, 32'h0);
    for (int n = 0; n < 40; n++)
      run_cmd($urandom_range(0, 1), 11'($urandom), $urandom_range(0, 8),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
              1, 0, 0, 32'h0);
`ifdef AVM_TIMEOUT_EN
    timeout_test();
    run_cmd(1, 11'h004, 0, -1, 0, 1, 0, 32'h0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/avalon_burst_master.md
AVALON_BURST_MASTER -- requirements
Module: avalon_burst_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, no-progress cycles before abort (used only when AVM_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write, 0=read), cmd_address in 11, cmd_burstcount in 10: command handshake.
REQ-005 SHALL have ports wdata_valid in 1, wdata_ready out 1, wdata in 32: write-beat source.
REQ-006 SHALL have ports rdata_valid out 1, rdata out 32: read-beat sink, no backpressure.
REQ-007 SHALL have Avalon-MM master ports address out 11, write out 1, read out 1, beginbursttransfer out 1, burstcount out 10, writedata out 32, waitrequest in 1, readdata in 32, readdatavalid in 1, writeresponsevalid in 1, response in 2.
REQ-008 SHALL have status ports busy out 1, done out 1 (one-cycle pulse), error out 1, timeout out 1.

Function
REQ-009 SHALL use FSM states IDLE, WR_BURST, WR_RESP, RD_REQ, RD_DATA, DONE.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; command accepted on cmd_valid && cmd_ready, latching address, burstcount, direction; beat counter cleared to 0.
REQ-011 SHALL, on accepted command with cmd_burstcount=0, issue no bus activity, go to DONE with error=1.
REQ-012 SHALL go IDLE->WR_BURST on accepted write, IDLE->RD_REQ on accepted read (burstcount>=1).
REQ-013 SHALL hold address and burstcount constant at latched values from acceptance until DONE.
REQ-014 SHALL in WR_BURST drive write=wdata_valid, writedata=wdata, wdata_ready=!waitrequest; beat transfers when write && !waitrequest.
REQ-015 SHALL assert beginbursttransfer for exactly one cycle: the first cycle of WR_BURST or RD_REQ, regardless of waitrequest or wdata_valid.
REQ-016 SHALL increment beat counter per transferred write beat; after beat burstcount transfers, go WR_BURST->WR_RESP next cycle with write=0.
REQ-017 SHALL in WR_RESP wait for writeresponsevalid; response!=2'b00 sets error; then go to DONE.
REQ-018 SHALL in RD_REQ hold read=1 until read && !waitrequest, then go to RD_DATA with read=0 next cycle.
REQ-019 SHALL in RD_DATA drive rdata_valid=readdatavalid, rdata=readdata combinationally; count beats; any beat with response!=2'b00 sets error (sticky).
REQ-020 SHALL go RD_DATA->DONE the cycle after beat burstcount arrives; extra readdatavalid outside RD_DATA ignored, rdata_valid=0.
REQ-021 SHALL in DONE pulse done=1 for one cycle and return to IDLE; error/timeout hold until next accepted command clears them.
REQ-022 SHALL drive busy=1 in every state except IDLE.
REQ-023 SHALL keep beat counter 10 bits; burstcount=1023 completes without wrap.

Reset
REQ-024 SHALL on rst=1 at clock edge, including mid-burst, force IDLE, counters 0, error=0, timeout=0.
REQ-025 SHALL output during/after reset: write=0, read=0, beginbursttransfer=0, cmd_ready=1 (once rst=0), wdata_ready=0, rdata_valid=0, busy=0, done=0, address=0, burstcount=0, writedata=0.

Configuration
REQ-026 SHALL, with AVM_TIMEOUT_EN defined, count consecutive non-IDLE/non-DONE cycles without beat transfer, request acceptance, or write response; at TIMEOUT_CYCLES go to DONE with error=1, timeout=1, write=0, read=0.
REQ-027 SHALL, without AVM_TIMEOUT_EN, omit the watchdog entirely, tie timeout=0, and wait indefinitely.

Verification
REQ-028 Write addr=0x010, burstcount=4, waitrequest=0, data 0x1..0x4 -> beginbursttransfer one cycle, 4 write beats, writeresponsevalid response=00 -> done pulse, error=0.
REQ-029 Same write with waitrequest high cycles 2-3 -> writedata held, beats not counted while stalled, exactly 4 beats accepted.
REQ-030 Read addr=0x100, burstcount=3, waitrequest=1 for 2 cycles -> read held 3 cycles, then 3 readdatavalid beats 0xA,0xB,0xC appear on rdata with rdata_valid, done pulse.
REQ-031 Read burstcount=2, second beat response=2'b10 -> error=1 after done, cleared on next accepted command.
REQ-032 rst=1 after 2 of 4 write beats -> next cycle write=0, busy=0, cmd_ready=1; new command accepted normally.
REQ-033 AVM_TIMEOUT_EN, TIMEOUT_CYCLES=16, waitrequest stuck 1 -> after 16 cycles done=1, error=1, timeout=1; command with burstcount=0 -> done, error=1, no write/read.
